// File: rtl/ppi_pkg.sv
// Shared constants, control-word bit positions and FSM state type for the
// parallel peripheral interface controller.
package ppi_pkg;

   localparam logic [1:0] ADDR_PA   = 2'd0;
   localparam logic [1:0] ADDR_PB   = 2'd1;
   localparam logic [1:0] ADDR_PC   = 2'd2;
   localparam logic [1:0] ADDR_CTRL = 2'd3;

   localparam int MODE_SET = 7;
   localparam int PA_DIR   = 4;
   localparam int PCH_DIR  = 3;
   localparam int PB_DIR   = 1;
   localparam int PCL_DIR  = 0;

   localparam logic [7:0] CTRL_RESET = 8'h9B;

   typedef enum logic [2:0] {
      ARM     = 3'd0,
      IDLE    = 3'd1,
      WR_ACT  = 3'd2,
      RD_ACT  = 3'd3,
      RECOVER = 3'd4
   } ppi_state_e;

endpackage

// File: rtl/ppi_strobe_sync.sv
// Synchroniser and edge detector for one active-low host strobe.
// 'primed' rises once the chain holds only post-reset pin samples.
module ppi_strobe_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic strobe_n,
   output logic level,
   output logic fell,
   output logic rose,
   output logic primed
);

   logic [STAGES-1:0] chain;
   logic [STAGES-1:0] fill;
   logic              prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '1;
         fill  <= '0;
         prev  <= 1'b1;
      end else begin
         chain <= {chain[STAGES-2:0], strobe_n};
         fill  <= {fill[STAGES-2:0], 1'b1};
         prev  <= chain[STAGES-1];
      end
   end

   assign level  = chain[STAGES-1];
   assign fell   = prev & ~chain[STAGES-1];
   assign rose   = ~prev & chain[STAGES-1];
   assign primed = fill[STAGES-1];

endmodule

// File: rtl/ppi_ctrl.sv
// Host bus interface and configuration owner for ports A, B and C.
// Define PPI_INPUT_SYNC_EN to pass port pins through two flops before the read mux.
module ppi_ctrl
   import ppi_pkg::*;
#(
   parameter int DW          = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cs_n,
   input  logic          rd_n,
   input  logic          wr_n,
   input  logic [1:0]    addr,
   input  logic [DW-1:0] d_in,
   output logic [DW-1:0] d_out,
   output logic          d_oe,
   input  logic [DW-1:0] pa_in,
   input  logic [DW-1:0] pb_in,
   input  logic [DW-1:0] pc_in,
   output logic [DW-1:0] pa_out,
   output logic [DW-1:0] pb_out,
   output logic [DW-1:0] pc_out,
   output logic [DW-1:0] pa_oe,
   output logic [DW-1:0] pb_oe,
   output logic [DW-1:0] pc_oe,
   output logic [7:0]    ctrl_word
);

   localparam int HALF = DW / 2;

   logic cs_lvl, cs_fell_unused, cs_rose_unused, cs_primed;
   logic rd_lvl, rd_fell, rd_rose, rd_primed;
   logic wr_lvl, wr_fell, wr_rose, wr_primed;

   ppi_strobe_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .strobe_n (cs_n),
      .level    (cs_lvl),
      .fell     (cs_fell_unused),
      .rose     (cs_rose_unused),
      .primed   (cs_primed)
   );

   ppi_strobe_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .strobe_n (rd_n),
      .level    (rd_lvl),
      .fell     (rd_fell),
      .rose     (rd_rose),
      .primed   (rd_primed)
   );

   ppi_strobe_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .strobe_n (wr_n),
      .level    (wr_lvl),
      .fell     (wr_fell),
      .rose     (wr_rose),
      .primed   (wr_primed)
   );

   logic [DW-1:0] pa_pin, pb_pin, pc_pin;

`ifdef PPI_INPUT_SYNC_EN
   logic [DW-1:0] pa_s1, pa_s2, pb_s1, pb_s2, pc_s1, pc_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pa_s1 <= '0;
         pa_s2 <= '0;
         pb_s1 <= '0;
         pb_s2 <= '0;
         pc_s1 <= '0;
         pc_s2 <= '0;
      end else begin
         pa_s1 <= pa_in;
         pa_s2 <= pa_s1;
         pb_s1 <= pb_in;
         pb_s2 <= pb_s1;
         pc_s1 <= pc_in;
         pc_s2 <= pc_s1;
      end
   end

   assign pa_pin = pa_s2;
   assign pb_pin = pb_s2;
   assign pc_pin = pc_s2;
`else
   assign pa_pin = pa_in;
   assign pb_pin = pb_in;
   assign pc_pin = pc_in;
`endif

   // Per-bit input masks: a 1 means the bit is an input and reads the pin.
   logic [DW-1:0] pa_in_mask, pb_in_mask, pc_in_mask;

   assign pa_in_mask = {DW{ctrl_word[PA_DIR]}};
   assign pb_in_mask = {DW{ctrl_word[PB_DIR]}};
   assign pc_in_mask = {{(DW-HALF){ctrl_word[PCH_DIR]}}, {HALF{ctrl_word[PCL_DIR]}}};

   logic [DW-1:0] rd_mux;

   always_comb begin
      rd_mux = '0;
      case (addr)
         ADDR_PA: rd_mux = (pa_out & ~pa_in_mask) | (pa_pin & pa_in_mask);
         ADDR_PB: rd_mux = (pb_out & ~pb_in_mask) | (pb_pin & pb_in_mask);
         ADDR_PC: rd_mux = (pc_out & ~pc_in_mask) | (pc_pin & pc_in_mask);
         default: rd_mux[7:0] = ctrl_word;
      endcase
   end

   ppi_state_e    state;
   logic [1:0]    addr_q;
   logic [DW-1:0] wdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ARM;
         addr_q    <= ADDR_PA;
         wdata_q   <= '0;
         ctrl_word <= CTRL_RESET;
         pa_out    <= '0;
         pb_out    <= '0;
         pc_out    <= '0;
         d_out     <= '0;
         d_oe      <= 1'b0;
      end else begin
         case (state)
            ARM: begin
               if (cs_primed && rd_primed && wr_primed && rd_lvl && wr_lvl) begin
                  state <= IDLE;
               end
            end
            IDLE: begin
               if (!rd_lvl && !wr_lvl) begin
                  state <= ARM;
               end else if (!cs_lvl && wr_fell) begin
                  addr_q  <= addr;
                  wdata_q <= d_in;
                  state   <= WR_ACT;
               end else if (!cs_lvl && rd_fell) begin
                  addr_q <= addr;
                  d_out  <= rd_mux;
                  d_oe   <= 1'b1;
                  state  <= RD_ACT;
               end
            end
            WR_ACT: begin
               if (cs_lvl) begin
                  state <= RECOVER;
               end else if (wr_rose) begin
                  case (addr_q)
                     ADDR_PA: pa_out <= wdata_q;
                     ADDR_PB: pb_out <= wdata_q;
                     ADDR_PC: pc_out <= wdata_q;
                     default: begin
                        if (wdata_q[MODE_SET]) begin
                           ctrl_word <= wdata_q[7:0];
                           pa_out    <= '0;
                           pb_out    <= '0;
                           pc_out    <= '0;
                        end else begin
                           pc_out[wdata_q[3:1]] <= wdata_q[0];
                        end
                     end
                  endcase
                  state <= RECOVER;
               end
            end
            RD_ACT: begin
               if (cs_lvl || rd_rose) begin
                  d_oe  <= 1'b0;
                  state <= RECOVER;
               end
            end
            RECOVER: state <= IDLE;
            default: state <= ARM;
         endcase
      end
   end

   // Output enables follow the committed control word one clock later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pa_oe <= '0;
         pb_oe <= '0;
         pc_oe <= '0;
      end else begin
         pa_oe <= ~pa_in_mask;
         pb_oe <= ~pb_in_mask;
         pc_oe <= ~pc_in_mask;
      end
   end

endmodule
